mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data ports, the arbiter and the single-port SRAM.
// The arbiter takes the slave modport; the cores plus the SRAM model take the master modport.
interface mem_arbiter_if #(
  parameter int AW = 14
);
  logic          im_req;
  logic [31:0]   im_addr;
  logic          im_gnt;
  logic          im_rvalid;
  logic [31:0]   im_rdata;

  logic          dm_req;
  logic [3:0]    dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;

  logic          sram_cs;
  logic          sram_oe;
  logic [3:0]    sram_web;
  logic [AW-1:0] sram_a;
  logic [31:0]   sram_di;
  logic [31:0]   sram_do;

  modport slave (
    input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_do,
    output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

  modport master (
    output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_do,
    input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one single-port SRAM with
// DM priority and a starvation counter that periodically forces an IM grant.
module mem_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         dbg_state,
  output logic [3:0]   dbg_starve_cnt
);

  // Handshake: a port holds req (and its address/data) until it sees gnt in the
  // same cycle; gnt is combinational and a granted read returns rvalid/rdata in
  // exactly the next cycle. A port may be re-granted while its rvalid is high.

  typedef enum logic {
    ARB      = 1'b0,
    FORCE_IM = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        im_gnt, dm_gnt, dm_rd;
  logic        im_rvalid_q, dm_rvalid_q;
  logic [31:0] im_rdata_q, dm_rdata_q;

  always_comb begin
    im_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;

    if (!rst) begin
      if (state == FORCE_IM) begin
        im_gnt = bus.im_req;
        dm_gnt = bus.dm_req & ~bus.im_req;
      end else begin
        dm_gnt = bus.dm_req;
        im_gnt = bus.im_req & ~bus.dm_req;
      end
    end

    if (bus.im_req && !im_gnt) starve_nxt = starve_cnt + 4'd1;
    else                       starve_nxt = 4'd0;

    case (state)
      ARB: begin
        if (bus.im_req && !im_gnt && (starve_cnt == 4'(STARVE_MAX - 1)))
          state_nxt = FORCE_IM;
      end
      FORCE_IM: state_nxt = ARB;
      default:  state_nxt = ARB;
    endcase
  end

  assign dm_rd = dm_gnt && (bus.dm_we == 4'h0);

  // SRAM drive: idle values unless a port holds the grant this cycle.
  always_comb begin
    bus.sram_cs  = 1'b0;
    bus.sram_oe  = 1'b0;
    bus.sram_web = 4'hF;
    bus.sram_a   = '0;
    bus.sram_di  = 32'h0;
    if (im_gnt) begin
      bus.sram_cs = 1'b1;
      bus.sram_oe = 1'b1;
      bus.sram_a  = bus.im_addr[AW+1:2];
    end else if (dm_gnt) begin
      bus.sram_cs  = 1'b1;
      bus.sram_oe  = (bus.dm_we == 4'h0);
      bus.sram_web = ~bus.dm_we;
      bus.sram_a   = bus.dm_addr[AW+1:2];
      bus.sram_di  = bus.dm_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB;
      starve_cnt  <= 4'd0;
      im_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      im_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      im_rvalid_q <= im_gnt;
      dm_rvalid_q <= dm_rd;
      // The SRAM is clocked on the falling edge, so sram_do already holds the
      // word for this cycle's grant when the rising edge arrives.
      if (im_gnt) im_rdata_q <= bus.sram_do;
      if (dm_rd)  dm_rdata_q <= bus.sram_do;
    end
  end

  assign bus.im_gnt    = im_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.im_rvalid = im_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.im_rdata  = im_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // Byte-offset and high address bits are not part of the word address.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.im_addr[1:0], bus.im_addr[31:AW+2],
                              bus.dm_addr[1:0], bus.dm_addr[31:AW+2]};

endmodule
